sobel_edge: RTL and testbench
=============================

# sobel_edge

Streaming 3×3 Sobel edge detector that sits directly downstream of the RGB-to-gray stage and consumes its gray/valid/hsync/vsync stream. It buffers two previous lines in on-chip RAM, forms a 3×3 window, computes |Gx|+|Gy|, and thresholds the result to a binary edge pixel (8'hFF / 8'h00). Sync signals are delayed to stay aligned with the pixel data, so the output drops straight into the display/VGA path.

## Interface
- IMG_WIDTH, 640, active pixels per line; line-buffer depth and column wrap point
- IMG_HEIGHT, 480, active lines per frame; row counter limit
- THRESHOLD, 11'd128, edge decision level compared against the 11-bit magnitude
- clk  input  1  pixel clock; all logic on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- gray_valid  input  1  input pixel valid
- gray_hsync  input  1  input line sync
- gray_vsync  input  1  input frame sync; a rising edge marks frame start
- gray  input  8  input gray pixel
- edge_valid  output  1  output pixel valid
- edge_hsync  output  1  gray_hsync delayed to match the data
- edge_vsync  output  1  gray_vsync delayed to match the data
- edge  output  8  8'hFF for an edge, 8'h00 otherwise

## Operation
- **Counters.**
  - col advances 0..IMG_WIDTH-1 on each gray_valid. On a valid at IMG_WIDTH-1, col wraps to 0 and row increments.
  - row saturates at IMG_HEIGHT-1.
  - A rising edge of gray_vsync (registered previous value low, current high) forces col=0, row=0.
  - If a valid pixel arrives in that same cycle, it is treated as pixel (0,0).
- **Line buffers.** Two IMG_WIDTH×8 RAMs, lb1 (row-1) and lb2 (row-2), addressed by col. On each valid pixel:
  - read lb1[col] and lb2[col];
  - write lb1[col]←gray and lb2[col]←old lb1[col], read-before-write at the same address.
- **Window.**
  - A 3×3 register array shifts one column left only on valid cycles.
  - The new right column is {lb2 data, lb1 data, gray} (top to bottom).
  - Window contents are held during gaps.
- **Gradient.** Signed 11-bit arithmetic:
  - Gx = (p13+2·p23+p33) − (p11+2·p21+p31)
  - Gy = (p31+2·p32+p33) − (p11+2·p12+p13)
  - mag = |Gx|+|Gy|, 11 bits unsigned, range 0..2040, no overflow.
- **Decision.** edge = (mag >= THRESHOLD) ? 8'hFF : 8'h00.
- **Geometry.**
  - Each input pixel at (row, col) yields exactly one output pixel, whose window is centred at (row-1, col-1).
  - Border outputs are forced to 8'h00 when row<2 or col<2 at input time.
  - Output count per frame equals input count.
  - The output image is shifted by one line and one column; this is accepted.
- **Invalid cycles.** Whenever edge_valid=0, edge=8'h00.
- **Reset.** Clears the counters, window, pipeline and all outputs. Line-buffer RAM contents are not cleared; border forcing masks them. A reset mid-frame makes the next valid pixel (0,0).

## Timing
- Reset values: edge_valid=0, edge_hsync=0, edge_vsync=0, edge=8'h00.
- Latency is fixed at 3 cycles from gray_valid to edge_valid:
  - S1: window/RAM read registered, with valid and border flag.
  - S2: Gx, Gy registered.
  - S3: mag compare, registered into edge.
- edge_hsync and edge_vsync are 3-cycle shift-register copies of the inputs, including during invalid cycles.
- The S1→S3 pipeline advances every cycle, carrying a valid tag; no backpressure.
- Arbitrary gaps in gray_valid are tolerated. Output for a given pixel is identical with or without gaps.
- Throughput: one pixel per clock.

## Test plan
Bench configuration unless stated: IMG_WIDTH=8, IMG_HEIGHT=8, THRESHOLD=128.

1. **Reset.** Hold rst_n=0 for 3 cycles with gray_valid=1 and gray=8'hAA.
   → All outputs stay 0, and for 3 cycles after release (data pipeline empty).
2. **Flat frame.** vsync pulse, then 64 pixels of gray=100 back-to-back.
   → 64 edge_valid pulses, each 3 cycles after its input, all edge=8'h00.
3. **Vertical step.** Cols 0-3=0, cols 4-7=200, every row. Centres at cols 3 and 4 give Gx=800.
   → edge=8'hFF for input cols 4 and 5 on rows 2..7. All other outputs 8'h00: 12 edge pixels per frame.
4. **Threshold boundary.** Repeat scenario 3 with THRESHOLD=800.
   → Same 12 pixels at 8'hFF (>= inclusive).
   Repeat with THRESHOLD=801.
   → All outputs 8'h00.
5. **Gapped valid.** Repeat scenario 3 with gray_valid deasserted every other cycle.
   → Edge value sequence identical to scenario 3; each output exactly 3 cycles after its input; hsync/vsync delayed exactly 3 cycles.
6. **Mid-frame vsync.** After 3 full rows, apply a vsync rising edge, then continue the step image.
   → Counters restart: the next 2 rows output all 8'h00, and edges reappear from the third row.

Source files
------------

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector: two line buffers, 3x3 window, |Gx|+|Gy| thresholded to 8'hFF/8'h00.
// Fixed 3-cycle latency from gray_valid_i to edge_valid_o, one pixel per clock, no backpressure.
module sobel_edge #(
  parameter int          IMG_WIDTH  = 640,
  parameter int          IMG_HEIGHT = 480,
  parameter logic [10:0] THRESHOLD  = 11'd128
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       gray_valid_i,
  input  logic       gray_hsync_i,
  input  logic       gray_vsync_i,
  input  logic [7:0] gray_i,
  output logic       edge_valid_o,
  output logic       edge_hsync_o,
  output logic       edge_vsync_o,
  output logic [7:0] edge_o
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // Weighted 1-2-1 column/row sum, zero-extended to 11 bits.
  function automatic logic [10:0] tap3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  function automatic logic [10:0] abs11(input logic [10:0] x);
    return x[10] ? (~x + 11'd1) : x;
  endfunction

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          vsync_q, vs_rise;

  logic [7:0] lb1_mem [IMG_WIDTH];
  logic [7:0] lb2_mem [IMG_WIDTH];
  logic [7:0] lb1_rd, lb2_rd;

  logic [2:0][2:0][7:0] win_q, win_d;
  logic                 s1_vld_q, s1_border_q, s1_border_d;
  logic [10:0]          gx_q, gx_d, gy_q, gy_d;
  logic                 s2_vld_q, s2_border_q;
  logic [10:0]          mag;
  logic [7:0]           edge_q, edge_d;
  logic                 edge_vld_q;
  logic [2:0]           hs_sh_q, vs_sh_q;

  // A vsync rising edge retargets the current cycle to (0,0), so a pixel arriving with it is pixel (0,0).
  always_comb begin
    vs_rise = gray_vsync_i & ~vsync_q;
    cur_col = vs_rise ? '0 : col_q;
    cur_row = vs_rise ? '0 : row_q;
    col_d   = cur_col;
    row_d   = cur_row;
    if (gray_valid_i) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        if (cur_row != ROW_LAST) row_d = cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
      end
    end
  end

  assign lb1_rd = lb1_mem[cur_col];
  assign lb2_rd = lb2_mem[cur_col];

  // Read-before-write: lb2 takes the old lb1 entry at the same column.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && gray_valid_i) begin
      lb1_mem[cur_col] <= gray_i;
      lb2_mem[cur_col] <= lb1_rd;
    end
  end

  always_comb begin
    win_d = win_q;
    if (gray_valid_i) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = gray_i;
    end
    s1_border_d = (cur_row < RW'(2)) || (cur_col < CW'(2));
  end

  // Window indices are [row][col]; [0][0] is p11 (top-left).
  always_comb begin
    gx_d = tap3(win_q[0][2], win_q[1][2], win_q[2][2]) - tap3(win_q[0][0], win_q[1][0], win_q[2][0]);
    gy_d = tap3(win_q[2][0], win_q[2][1], win_q[2][2]) - tap3(win_q[0][0], win_q[0][1], win_q[0][2]);
    mag  = abs11(gx_q) + abs11(gy_q);
    edge_d = (s2_vld_q && !s2_border_q && (mag >= THRESHOLD)) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      col_q       <= '0;
      row_q       <= '0;
      vsync_q     <= 1'b0;
      win_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_border_q <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      s2_vld_q    <= 1'b0;
      s2_border_q <= 1'b0;
      edge_q      <= 8'h00;
      edge_vld_q  <= 1'b0;
      hs_sh_q     <= '0;
      vs_sh_q     <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      vsync_q     <= gray_vsync_i;
      win_q       <= win_d;
      s1_vld_q    <= gray_valid_i;
      s1_border_q <= s1_border_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      s2_vld_q    <= s1_vld_q;
      s2_border_q <= s1_border_q;
      edge_q      <= edge_d;
      edge_vld_q  <= s2_vld_q;
      hs_sh_q     <= {hs_sh_q[1:0], gray_hsync_i};
      vs_sh_q     <= {vs_sh_q[1:0], gray_vsync_i};
    end
  end

  assign edge_valid_o = edge_vld_q;
  assign edge_o       = edge_q;
  assign edge_hsync_o = hs_sh_q[2];
  assign edge_vsync_o = vs_sh_q[2];

endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge on an 8x8 image; three instances differ only in THRESHOLD (128, 800, 801).
module tb_sobel_edge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, gv, ghs, gvs;
  logic [7:0] gray;
  logic [2:0] ev, ehs, evs;
  logic [7:0] eo [3];

  sobel_edge #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .THRESHOLD(11'd128)) u_t128 (
    .clk_i(clk), .rst_n_i(rst_n), .gray_valid_i(gv), .gray_hsync_i(ghs), .gray_vsync_i(gvs), .gray_i(gray),
    .edge_valid_o(ev[0]), .edge_hsync_o(ehs[0]), .edge_vsync_o(evs[0]), .edge_o(eo[0]));
  sobel_edge #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .THRESHOLD(11'd800)) u_t800 (
    .clk_i(clk), .rst_n_i(rst_n), .gray_valid_i(gv), .gray_hsync_i(ghs), .gray_vsync_i(gvs), .gray_i(gray),
    .edge_valid_o(ev[1]), .edge_hsync_o(ehs[1]), .edge_vsync_o(evs[1]), .edge_o(eo[1]));
  sobel_edge #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .THRESHOLD(11'd801)) u_t801 (
    .clk_i(clk), .rst_n_i(rst_n), .gray_valid_i(gv), .gray_hsync_i(ghs), .gray_vsync_i(gvs), .gray_i(gray),
    .edge_valid_o(ev[2]), .edge_hsync_o(ehs[2]), .edge_vsync_o(evs[2]), .edge_o(eo[2]));

  typedef struct packed {
    logic       v;
    logic       hs;
    logic       vs;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } exp_t;

  exp_t pipe1, pipe2, pipe3;
  int   vectors = 0;
  int   miscompares = 0;
  int   vld_cnt = 0;
  int   ff_cnt [3];
  int   v0;
  int   f0 [3];

  // One clock: drive at negedge, DUT samples at posedge, outputs checked at the next negedge
  // against what was driven three posedges earlier.
  task automatic cyc(input logic v, input logic hs, input logic vs, input logic [7:0] px,
                     input logic [7:0] e128, input logic [7:0] e800, input logic [7:0] e801);
    exp_t       n;
    logic [7:0] ee [3];
    gv = v; ghs = hs; gvs = vs; gray = px;
    @(posedge clk);
    n.v  = v & rst_n;
    n.hs = hs & rst_n;
    n.vs = vs & rst_n;
    n.e0 = n.v ? e128 : 8'h00;
    n.e1 = n.v ? e800 : 8'h00;
    n.e2 = n.v ? e801 : 8'h00;
    pipe3 = pipe2; pipe2 = pipe1; pipe1 = n;
    @(negedge clk);
    ee[0] = pipe3.e0; ee[1] = pipe3.e1; ee[2] = pipe3.e2;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      assert (ev[i] === pipe3.v) else begin
        miscompares++;
        $error("FAIL valid[%0d] t=%0t observed %b expected %b", i, $time, ev[i], pipe3.v);
      end
      vectors++;
      assert (eo[i] === ee[i]) else begin
        miscompares++;
        $error("FAIL edge[%0d] t=%0t observed %h expected %h", i, $time, eo[i], ee[i]);
      end
      vectors++;
      assert (ehs[i] === pipe3.hs) else begin
        miscompares++;
        $error("FAIL hsync[%0d] t=%0t observed %b expected %b", i, $time, ehs[i], pipe3.hs);
      end
      vectors++;
      assert (evs[i] === pipe3.vs) else begin
        miscompares++;
        $error("FAIL vsync[%0d] t=%0t observed %b expected %b", i, $time, evs[i], pipe3.vs);
      end
      if (ev[i] === 1'b1 && eo[i] === 8'hFF) ff_cnt[i]++;
    end
    if (ev[0] === 1'b1) vld_cnt++;
  endtask

  task automatic check_cnt(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic vs_pulse();
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  // Step image: cols 0-3 = 0, cols 4-7 = 200. Only input cols 4 and 5 of rows >= 2 see |Gx| = 800.
  task automatic step_rows(input int rows, input bit gapped);
    logic [7:0] px, e;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < 8; c++) begin
        px = (c >= 4) ? 8'd200 : 8'd0;
        e  = (r >= 2 && (c == 4 || c == 5)) ? 8'hFF : 8'h00;
        cyc(1'b1, 1'b0, 1'b0, px, e, e, 8'h00);
        if (gapped) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      end
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    end
  endtask

  task automatic snap();
    v0 = vld_cnt;
    for (int i = 0; i < 3; i++) f0[i] = ff_cnt[i];
  endtask

  initial begin
    for (int i = 0; i < 3; i++) ff_cnt[i] = 0;
    pipe1 = '0; pipe2 = '0; pipe3 = '0;
    rst_n = 1'b0; gv = 1'b0; ghs = 1'b0; gvs = 1'b0; gray = 8'h00;

    // Reset held with live input; then pixels right after release are border pixels.
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 8'hAA, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 8'hAA, 8'h00, 8'h00, 8'h00);
    idle(4);

    // Flat frame, back-to-back.
    vs_pulse();
    snap();
    for (int k = 0; k < 64; k++) cyc(1'b1, 1'b0, 1'b0, 8'd100, 8'h00, 8'h00, 8'h00);
    idle(4);
    check_cnt("flat_valid_count", vld_cnt - v0, 64);
    check_cnt("flat_edge_count", ff_cnt[0] - f0[0], 0);

    // Vertical step, contiguous.
    vs_pulse();
    snap();
    step_rows(8, 1'b0);
    idle(4);
    check_cnt("step_valid_count", vld_cnt - v0, 64);
    check_cnt("step_edges_t128", ff_cnt[0] - f0[0], 12);
    check_cnt("step_edges_t800", ff_cnt[1] - f0[1], 12);
    check_cnt("step_edges_t801", ff_cnt[2] - f0[2], 0);

    // Vertical step with valid every other cycle.
    vs_pulse();
    snap();
    step_rows(8, 1'b1);
    idle(4);
    check_cnt("gap_valid_count", vld_cnt - v0, 64);
    check_cnt("gap_edges_t128", ff_cnt[0] - f0[0], 12);
    check_cnt("gap_edges_t801", ff_cnt[2] - f0[2], 0);

    // Vsync after three rows restarts the counters.
    vs_pulse();
    snap();
    step_rows(3, 1'b0);
    vs_pulse();
    step_rows(8, 1'b0);
    idle(4);
    check_cnt("midframe_valid_count", vld_cnt - v0, 88);
    check_cnt("midframe_edges_t128", ff_cnt[0] - f0[0], 14);
    check_cnt("midframe_edges_t800", ff_cnt[1] - f0[1], 14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
